// File: rtl/seq_scan_pkg.sv
// Shared types and default pattern constants for the sequential scan arbiter.
// Optional overlap counting is selected with the SEQ_SCAN_OVERLAP_EN macro (see pattern_det_core).
package seq_scan_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SCAN = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int         DEF_PLEN    = 4;
    localparam logic [3:0] DEF_PATTERN = 4'b0110;

endpackage

// File: rtl/pattern_det_core.sv
// Mealy serial pattern detector: hit is combinational on the current bit and the stored history.
// Define SEQ_SCAN_OVERLAP_EN to count overlapping hits; otherwise a hit restarts the fill.
module pattern_det_core
    import seq_scan_pkg::*;
#(
    parameter int              PLEN    = DEF_PLEN,
    parameter logic [PLEN-1:0] PATTERN = PLEN'(DEF_PATTERN)
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic vld,
    input  logic bit_in,
    output logic hit
);

    localparam int FW = $clog2(PLEN + 1);

    logic [PLEN-2:0] window;
    logic [FW-1:0]   fill;
    logic [PLEN-1:0] cand;

    assign cand = {window, bit_in};
    assign hit  = vld && (fill >= FW'(PLEN - 1)) && (cand == PATTERN);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            window <= '0;
            fill   <= '0;
        end else if (vld) begin
            window <= cand[PLEN-2:0];
`ifdef SEQ_SCAN_OVERLAP_EN
            fill <= (fill == FW'(PLEN)) ? fill : fill + 1'b1;
`else
            // A hit consumes its bits: the next match must be built from fresh input.
            if (hit)
                fill <= '0;
            else
                fill <= (fill == FW'(PLEN)) ? fill : fill + 1'b1;
`endif
        end
    end

endmodule

// File: rtl/seq_scan_arbiter.sv
// Round-robin arbiter that scans one requester word at a time through a shared pattern detector.
// Overlapping-hit counting is enabled by defining SEQ_SCAN_OVERLAP_EN.
module seq_scan_arbiter
    import seq_scan_pkg::*;
#(
    parameter int              NREQ    = 4,
    parameter int              W       = 8,
    parameter int              PLEN    = DEF_PLEN,
    parameter logic [PLEN-1:0] PATTERN = PLEN'(DEF_PATTERN)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*W-1:0]        data_in,
    output logic [NREQ-1:0]          grant,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(NREQ)-1:0]  done_id,
    output logic [$clog2(W+1)-1:0]   match_cnt
);

    localparam int IDW = $clog2(NREQ);
    localparam int CW  = $clog2(W + 1);
    localparam int BW  = $clog2(W);

    state_t         state, next_state;
    logic [IDW-1:0] ptr, id, pick;
    logic [W-1:0]   shreg;
    logic [CW-1:0]  cnt;
    logic [BW-1:0]  bit_idx;
    logic           hit;
    logic           last_bit;

    assign last_bit = (bit_idx == BW'(W - 1));

    // First requester at or after the pointer, wrapping around.
    always_comb begin
        pick = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[(int'(ptr) + i) % NREQ])
                pick = IDW'((int'(ptr) + i) % NREQ);
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (|req) next_state = LOAD;
            LOAD: next_state = SCAN;
            SCAN: if (last_bit) next_state = DONE;
            DONE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr       <= '0;
            id        <= '0;
            shreg     <= '0;
            cnt       <= '0;
            bit_idx   <= '0;
            done_id   <= '0;
            match_cnt <= '0;
        end else begin
            case (state)
                IDLE: if (|req) id <= pick;
                LOAD: begin
                    shreg   <= data_in[int'(id)*W +: W];
                    cnt     <= '0;
                    bit_idx <= '0;
                end
                SCAN: begin
                    shreg   <= shreg << 1;
                    cnt     <= cnt + CW'(hit);
                    bit_idx <= bit_idx + 1'b1;
                    // Result registers update once per word so they hold until the next done.
                    if (last_bit) begin
                        match_cnt <= cnt + CW'(hit);
                        done_id   <= id;
                    end
                end
                DONE: ptr <= (id == IDW'(NREQ - 1)) ? '0 : id + 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        grant = '0;
        if (state == LOAD || state == SCAN)
            grant[id] = 1'b1;
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    pattern_det_core #(
        .PLEN    (PLEN),
        .PATTERN (PATTERN)
    ) u_core (
        .clk    (clk),
        .reset  (reset),
        .clr    (state == LOAD),
        .vld    (state == SCAN),
        .bit_in (shreg[W-1]),
        .hit    (hit)
    );

endmodule
